mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter SP_INIT, default 20'h003FE, SP reset value in 16-bit words.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset_b  in  1  asynchronous, active-low reset.
REQ-004 i_valid  in  1  upstream request valid.
REQ-005 o_ready  out  1  block accepts a request this cycle.
REQ-006 i_op  in  3  000 NOP, 001 LOAD, 010 STORE, 011 PUSH16, 100 POP16, 101 PUSH32 (CALL), 110 POP32 (RET), 111 reserved.
REQ-007 i_en32  in  1  LOAD/STORE width: 1 = 32-bit, 0 = 16-bit.
REQ-008 i_ea  in  20  effective address for LOAD/STORE.
REQ-009 i_wdata  in  32  store/push data; the low half is used for 16-bit ops.
REQ-010 o_mem_read, o_mem_write, o_mem_en32  out  1 each  data-memory controls.
REQ-011 o_mem_address  out  20; o_mem_wdata  out  32  data-memory address and write data.
REQ-012 i_mem_rdata  in  32  data-memory read data, valid the cycle after the read edge.
REQ-013 o_rdata  out  32; o_rdata_valid  out  1  load/pop result and one-cycle qualifier.
REQ-014 o_sp  out  20  current stack pointer, which points to the next free word.

Function
REQ-015 The FSM SHALL have two states: IDLE and RD_WAIT, with o_ready = 1 only in IDLE.
REQ-016 Accept SHALL occur when i_valid && o_ready; o_mem_* SHALL be driven combinationally from the accepted request in the accept cycle, and all o_mem_read/o_mem_write SHALL be 0 otherwise.
REQ-017 LOAD SHALL drive read = 1, address = i_ea, en32 = i_en32.
REQ-018 STORE SHALL drive write = 1, address = i_ea, en32 = i_en32, wdata = i_wdata.
REQ-019 PUSH16 SHALL write i_wdata[15:0] at SP with en32 = 0, then update SP <= SP-1.
REQ-020 POP16 SHALL read at SP+1 with en32 = 0, then update SP <= SP+1.
REQ-021 PUSH32 SHALL write at SP-1 with en32 = 1 (low half to SP-1, high half to SP), then update SP <= SP-2.
REQ-022 POP32 SHALL read at SP+1 with en32 = 1, then update SP <= SP+2.
REQ-023 SP arithmetic SHALL be modulo 2^20, wrapping silently (for example, 20'h00000-1 = 20'hFFFFF).
REQ-024 SP SHALL update at the end of the accept cycle; the o_mem_address computation SHALL use the pre-update SP.
REQ-025 A read op accepted in cycle t SHALL cause a transition to RD_WAIT for cycle t+1; at the end of t+1, i_mem_rdata is captured into o_rdata and the FSM returns to IDLE.
REQ-026 o_rdata_valid SHALL be high for exactly cycle t+2 (read latency 2, read throughput 1 per 2 cycles).
REQ-027 A new request SHALL be acceptable in cycle t+2, concurrently with o_rdata_valid.
REQ-028 Write ops SHALL complete in the accept cycle: the FSM stays in IDLE, giving throughput of 1 per cycle, and o_rdata_valid is not asserted.
REQ-029 For a 16-bit read, o_rdata SHALL be {16'b0, RAM word}, taken as-is from i_mem_rdata.
REQ-030 NOP, reserved op 111, and i_valid = 0 SHALL produce no memory access and no SP change.
REQ-031 o_rdata SHALL hold its last captured value until the next capture.

Reset
REQ-032 While reset_b = 0, the block SHALL force state = IDLE, SP = SP_INIT, o_rdata = 0, o_rdata_valid = 0, o_ready = 0, and all o_mem_read/o_mem_write = 0.
REQ-033 Deassertion of reset_b SHALL make the block accept requests from the first following clock edge.
REQ-034 Reset during RD_WAIT SHALL abort the read, with no o_rdata_valid pulse afterwards.

Structure
REQ-035 The op encodings, the FSM state encoding, and the address width (20) SHALL reside in a shared package, mem_pkg.
REQ-036 The SP register and its add/subtract logic SHALL be a sub-module, sp_unit, with inputs inc1/dec1/inc2/dec2 and output sp.
REQ-037 No memory array SHALL be instantiated inside this block.

Verification
REQ-038 The bench SHALL check that after reset, o_sp = 20'h003FE, o_ready = 1, and all mem strobes are 0.
REQ-039 The bench SHALL check that PUSH16 0x1234 then POP16 produces a write at 0x3FE, SP = 0x3FD, then a read at 0x3FE, o_rdata = 0x00001234 two cycles after POP accept, and SP = 0x3FE.
REQ-040 The bench SHALL check that PUSH32 0xDEADBEEF produces a write at 0x3FD with en32 = 1 and SP = 0x3FC, and that POP32 then gives o_rdata = 0xDEADBEEF and SP = 0x3FE.
REQ-041 The bench SHALL check that with SP forced to 0x00000 via SP_INIT, PUSH16 gives SP = 0xFFFFF, and POP16 then reads at 0x00000 with SP = 0x00000.
REQ-042 The bench SHALL check that back-to-back LOAD, STORE requests with i_valid held high show o_ready = 0 in the cycle after LOAD, the STORE issued in cycle t+2, and o_rdata_valid high in that same cycle.
REQ-043 The bench SHALL check that reset_b pulsed low during RD_WAIT produces no o_rdata_valid, SP = SP_INIT, and FSM = IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage controller.
// Op codes, FSM states and address width.
package mem_pkg;

    localparam int AW = 20;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_LOAD   = 3'b001,
        OP_STORE  = 3'b010,
        OP_PUSH16 = 3'b011,
        OP_POP16  = 3'b100,
        OP_PUSH32 = 3'b101,
        OP_POP32  = 3'b110,
        OP_RSVD   = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } state_e;

    function automatic logic is_read(op_e op);
        return (op == OP_LOAD) || (op == OP_POP16) || (op == OP_POP32);
    endfunction

endpackage

// File: rtl/sp_unit.sv
// Stack pointer register with +/-1 and +/-2 updates.
// Arithmetic wraps modulo 2^AW.
module sp_unit
    import mem_pkg::*;
#(
    parameter logic [AW-1:0] SP_INIT = 20'h003FE
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          inc1,
    input  logic          dec1,
    input  logic          inc2,
    input  logic          dec2,
    output logic [AW-1:0] sp
);

    logic [AW-1:0] delta;

    always_comb begin
        delta = '0;
        unique case (1'b1)
            inc1:    delta = AW'(1);
            dec1:    delta = '1;
            inc2:    delta = AW'(2);
            dec2:    delta = ~AW'(1);
            default: delta = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sp <= SP_INIT;
        end else begin
            sp <= sp + delta;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: load/store and stack ops to a
// synchronous data memory with a one-cycle read wait state.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter logic [AW-1:0] SP_INIT = 20'h003FE
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [2:0]    i_op,
    input  logic          i_en32,
    input  logic [AW-1:0] i_ea,
    input  logic [31:0]   i_wdata,
    output logic          o_mem_read,
    output logic          o_mem_write,
    output logic          o_mem_en32,
    output logic [AW-1:0] o_mem_address,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata,
    output logic [31:0]   o_rdata,
    output logic          o_rdata_valid,
    output logic [AW-1:0] o_sp
);

    state_e        state;
    state_e        state_nxt;
    op_e           op;
    logic          accept;
    logic          rd_en32;
    logic          inc1, dec1, inc2, dec2;
    logic [AW-1:0] sp_p1;
    logic [AW-1:0] sp_m1;

    assign op      = op_e'(i_op);
    assign o_ready = reset_b && (state == S_IDLE);
    assign accept  = i_valid && o_ready;
    assign sp_p1   = o_sp + AW'(1);
    assign sp_m1   = o_sp - AW'(1);

    sp_unit #(
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk     (clk),
        .reset_b (reset_b),
        .inc1    (inc1),
        .dec1    (dec1),
        .inc2    (inc2),
        .dec2    (dec2),
        .sp      (o_sp)
    );

    always_comb begin
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_mem_en32    = 1'b0;
        o_mem_address = '0;
        o_mem_wdata   = '0;
        inc1          = 1'b0;
        dec1          = 1'b0;
        inc2          = 1'b0;
        dec2          = 1'b0;
        state_nxt     = S_IDLE;
        if (accept) begin
            case (op)
                OP_LOAD: begin
                    o_mem_read    = 1'b1;
                    o_mem_address = i_ea;
                    o_mem_en32    = i_en32;
                end
                OP_STORE: begin
                    o_mem_write   = 1'b1;
                    o_mem_address = i_ea;
                    o_mem_en32    = i_en32;
                    o_mem_wdata   = i_wdata;
                end
                OP_PUSH16: begin
                    o_mem_write   = 1'b1;
                    o_mem_address = o_sp;
                    o_mem_wdata   = {16'h0, i_wdata[15:0]};
                    dec1          = 1'b1;
                end
                OP_POP16: begin
                    o_mem_read    = 1'b1;
                    o_mem_address = sp_p1;
                    inc1          = 1'b1;
                end
                OP_PUSH32: begin
                    o_mem_write   = 1'b1;
                    o_mem_en32    = 1'b1;
                    o_mem_address = sp_m1;
                    o_mem_wdata   = i_wdata;
                    dec2          = 1'b1;
                end
                OP_POP32: begin
                    o_mem_read    = 1'b1;
                    o_mem_en32    = 1'b1;
                    o_mem_address = sp_p1;
                    inc2          = 1'b1;
                end
                default: ;
            endcase
            if (is_read(op)) state_nxt = S_RD_WAIT;
        end
    end

    // Read data arrives during RD_WAIT; 16-bit results are zero-extended
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state         <= S_IDLE;
            rd_en32       <= 1'b0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
        end else begin
            state         <= state_nxt;
            o_rdata_valid <= (state == S_RD_WAIT);
            if (accept && o_mem_read) rd_en32 <= o_mem_en32;
            if (state == S_RD_WAIT) begin
                o_rdata <= rd_en32 ? i_mem_rdata
                                   : {16'h0, i_mem_rdata[15:0]};
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: word-addressed memory model, reference
// model checked every cycle, plus literal directed checks.
module tb_mem_stage_ctrl;
    import mem_pkg::*;

    localparam logic [19:0] INIT = 20'h003FE;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        en32 = 1'b0;
    logic [19:0] ea = '0;
    logic [31:0] wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        ready, mrd, mwr, men32, rvalid;
    logic [19:0] maddr, sp;
    logic [31:0] mwd, rdata;

    logic        b_valid = 1'b0;
    logic [2:0]  b_op = 3'd0;
    logic [31:0] b_wdata = '0;
    logic [31:0] b_mem_rdata = 32'h0000ABCD;
    logic        b_ready, b_mrd, b_mwr, b_men32, b_rvalid;
    logic [19:0] b_maddr, b_sp;
    logic [31:0] b_mwd, b_rdata;

    mem_stage_ctrl dut (
        .clk(clk), .reset_b(rst_b), .i_valid(valid), .o_ready(ready),
        .i_op(op), .i_en32(en32), .i_ea(ea), .i_wdata(wdata),
        .o_mem_read(mrd), .o_mem_write(mwr), .o_mem_en32(men32),
        .o_mem_address(maddr), .o_mem_wdata(mwd),
        .i_mem_rdata(mem_rdata), .o_rdata(rdata),
        .o_rdata_valid(rvalid), .o_sp(sp)
    );

    mem_stage_ctrl #(.SP_INIT(20'h00000)) dut0 (
        .clk(clk), .reset_b(rst_b), .i_valid(b_valid), .o_ready(b_ready),
        .i_op(b_op), .i_en32(1'b0), .i_ea(20'h0), .i_wdata(b_wdata),
        .o_mem_read(b_mrd), .o_mem_write(b_mwr), .o_mem_en32(b_men32),
        .o_mem_address(b_maddr), .o_mem_wdata(b_mwd),
        .i_mem_rdata(b_mem_rdata), .o_rdata(b_rdata),
        .o_rdata_valid(b_rvalid), .o_sp(b_sp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory seen by the DUT (16-bit words)
    logic [15:0] ram [int];
    logic [15:0] refm [int];

    function automatic logic [15:0] ram_get(logic [19:0] a);
        return ram.exists(int'(a)) ? ram[int'(a)] : 16'h0;
    endfunction

    function automatic logic [15:0] ref_get(logic [19:0] a);
        return refm.exists(int'(a)) ? refm[int'(a)] : 16'h0;
    endfunction

    always @(posedge clk) begin
        if (mwr) begin
            ram[int'(maddr)] = mwd[15:0];
            if (men32) ram[int'(maddr + 20'd1)] = mwd[31:16];
        end
        if (mrd) begin
            mem_rdata <= {men32 ? ram_get(maddr + 20'd1) : 16'h0,
                          ram_get(maddr)};
        end
    end

    // Reference model: stack pointer, memory image, pending read
    logic [19:0] m_sp = INIT;
    bit          m_wait = 0;
    bit          m_vpend = 0;
    logic [19:0] m_raddr = '0;
    bit          m_ren32 = 0;
    logic [31:0] m_rdata = '0;

    initial forever begin
        bit          e_ready, acc, e_rd, e_wr, e_en;
        logic [19:0] e_addr;
        logic [31:0] e_wd, wmask;
        @(negedge clk);
        if (!rst_b) begin
            m_sp = INIT; m_wait = 0; m_vpend = 0; m_rdata = '0;
        end
        e_ready = rst_b && !m_wait;
        acc = valid && e_ready;
        e_rd = 0; e_wr = 0; e_en = 0; e_addr = '0; e_wd = '0;
        wmask = 32'hFFFFFFFF;
        if (acc) begin
            case (op)
                3'd1: begin e_rd = 1; e_addr = ea; e_en = en32; end
                3'd2: begin e_wr = 1; e_addr = ea; e_en = en32; e_wd = wdata; end
                3'd3: begin e_wr = 1; e_addr = m_sp; e_wd = wdata; wmask = 32'h0000FFFF; end
                3'd4: begin e_rd = 1; e_addr = m_sp + 20'd1; end
                3'd5: begin e_wr = 1; e_en = 1; e_addr = m_sp - 20'd1; e_wd = wdata; end
                3'd6: begin e_rd = 1; e_en = 1; e_addr = m_sp + 20'd1; end
                default: ;
            endcase
        end
        chk("m_ready", 32'(ready), 32'(e_ready));
        chk("m_read", 32'(mrd), 32'(e_rd));
        chk("m_write", 32'(mwr), 32'(e_wr));
        chk("m_rvalid", 32'(rvalid), 32'(m_vpend));
        chk("m_rdata", rdata, m_rdata);
        chk("m_sp", 32'(sp), 32'(m_sp));
        if (e_rd || e_wr) begin
            chk("m_addr", 32'(maddr), 32'(e_addr));
            chk("m_en32", 32'(men32), 32'(e_en));
        end
        if (e_wr) chk("m_wdata", mwd & wmask, e_wd & wmask);
        if (rst_b) begin
            m_vpend = m_wait;
            if (m_wait) begin
                m_rdata = {m_ren32 ? ref_get(m_raddr + 20'd1) : 16'h0,
                           ref_get(m_raddr)};
                m_wait = 0;
            end
            if (e_wr) begin
                refm[int'(e_addr)] = e_wd[15:0];
                if (e_en) refm[int'(e_addr + 20'd1)] = e_wd[31:16];
            end
            if (e_rd) begin
                m_wait = 1; m_raddr = e_addr; m_ren32 = e_en;
            end
            if (acc) begin
                case (op)
                    3'd3: m_sp = m_sp - 20'd1;
                    3'd4: m_sp = m_sp + 20'd1;
                    3'd5: m_sp = m_sp - 20'd2;
                    3'd6: m_sp = m_sp + 20'd2;
                    default: ;
                endcase
            end
        end
    end

    task automatic step(bit v, logic [2:0] o, bit e,
                        logic [19:0] a, logic [31:0] d);
        @(posedge clk);
        #1;
        valid = v; op = o; en32 = e; ea = a; wdata = d;
        @(negedge clk);
    endtask

    task automatic bstep(bit v, logic [2:0] o, logic [31:0] d);
        @(posedge clk);
        #1;
        b_valid = v; b_op = o; b_wdata = d;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_strobes", 32'({mrd, mwr}), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        chk("post_rst_sp", 32'(sp), 32'h003FE);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_strobes", 32'({mrd, mwr}), 32'd0);

        step(1, 3'd3, 0, 20'h0, 32'h00001234);
        chk("push16_wr", 32'(mwr), 32'd1);
        chk("push16_addr", 32'(maddr), 32'h3FE);
        chk("push16_en32", 32'(men32), 32'd0);
        chk("push16_data", 32'(mwd[15:0]), 32'h1234);
        step(1, 3'd4, 0, 20'h0, 32'h0);
        chk("push16_sp", 32'(sp), 32'h3FD);
        chk("pop16_rd", 32'(mrd), 32'd1);
        chk("pop16_addr", 32'(maddr), 32'h3FE);
        step(0, 3'd0, 0, 20'h0, 32'h0);
        chk("pop16_wait_ready", 32'(ready), 32'd0);
        step(0, 3'd0, 0, 20'h0, 32'h0);
        chk("pop16_rvalid", 32'(rvalid), 32'd1);
        chk("pop16_rdata", rdata, 32'h00001234);
        chk("pop16_sp", 32'(sp), 32'h3FE);

        step(1, 3'd5, 0, 20'h0, 32'hDEADBEEF);
        chk("push32_addr", 32'(maddr), 32'h3FD);
        chk("push32_en32", 32'(men32), 32'd1);
        chk("push32_data", mwd, 32'hDEADBEEF);
        step(1, 3'd6, 0, 20'h0, 32'h0);
        chk("push32_sp", 32'(sp), 32'h3FC);
        chk("pop32_addr", 32'(maddr), 32'h3FD);
        step(0, 3'd0, 0, 20'h0, 32'h0);
        step(0, 3'd0, 0, 20'h0, 32'h0);
        chk("pop32_rvalid", 32'(rvalid), 32'd1);
        chk("pop32_rdata", rdata, 32'hDEADBEEF);
        chk("pop32_sp", 32'(sp), 32'h3FE);

        step(1, 3'd1, 0, 20'h3FD, 32'h0);
        chk("b2b_load_rd", 32'(mrd), 32'd1);
        step(1, 3'd2, 1, 20'h100, 32'hCAFEF00D);
        chk("b2b_t1_ready", 32'(ready), 32'd0);
        chk("b2b_t1_wr", 32'(mwr), 32'd0);
        step(1, 3'd2, 1, 20'h100, 32'hCAFEF00D);
        chk("b2b_t2_wr", 32'(mwr), 32'd1);
        chk("b2b_t2_addr", 32'(maddr), 32'h100);
        chk("b2b_t2_rvalid", 32'(rvalid), 32'd1);
        chk("b2b_t2_rdata", rdata, 32'h0000BEEF);
        step(0, 3'd0, 0, 20'h0, 32'h0);

        bstep(1, 3'd3, 32'h00000055);
        chk("wrap_push_wr", 32'(b_mwr), 32'd1);
        chk("wrap_push_addr", 32'(b_maddr), 32'h00000);
        bstep(1, 3'd4, 32'h0);
        chk("wrap_push_sp", 32'(b_sp), 32'hFFFFF);
        chk("wrap_pop_rd", 32'(b_mrd), 32'd1);
        chk("wrap_pop_addr", 32'(b_maddr), 32'h00000);
        bstep(0, 3'd0, 32'h0);
        bstep(0, 3'd0, 32'h0);
        chk("wrap_pop_sp", 32'(b_sp), 32'h00000);
        chk("wrap_pop_rvalid", 32'(b_rvalid), 32'd1);
        chk("wrap_pop_rdata", b_rdata, 32'h0000ABCD);

        step(1, 3'd4, 0, 20'h0, 32'h0);
        chk("abort_rd", 32'(mrd), 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("abort_rst_ready", 32'(ready), 32'd0);
        @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        chk("abort_sp", 32'(sp), 32'(INIT));
        chk("abort_idle", 32'(ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 3'd0, 0, 20'h0, 32'h0);
            chk("abort_no_rvalid", 32'(rvalid), 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst_b = ($urandom_range(0, 249) != 0);
            valid = ($urandom_range(0, 3) != 0);
            op    = 3'($urandom_range(0, 7));
            en32  = 1'($urandom);
            ea    = 20'h3E0 + 20'($urandom_range(0, 31));
            wdata = $urandom;
        end
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
